bin_bcd_seq: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It processes one input bit per clock, so the logic cost is one add-3 stage per digit instead of a fully unrolled array. Optional two's-complement mode and a truncation flag are included. It sits between arithmetic/counter blocks and the 7-segment display multiplexers, with a start/done handshake so producers can pace conversions.

---
 rtl/bin_bcd_seq_if.sv | 17 +
 rtl/bin_bcd_seq.sv | 117 +++++++++++
 tb/tb_bin_bcd_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_bcd_seq_if.sv
// Start/done handshake and result bus between a binary producer and the
// bin_bcd_seq converter.
interface bin_bcd_seq_if #(
  parameter int W = 16,
  parameter int D = 5
);
  logic           start;
  logic [W-1:0]   bin;
  logic           ready;
  logic           done;
  logic [4*D-1:0] bcd;
  logic           neg;
  logic           overflow;

  modport master (output start, bin, input ready, done, bcd, neg, overflow);
  modport slave  (input start, bin, output ready, done, bcd, neg, overflow);
endinterface

// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one operand bit per clock,
// optional two's-complement input, sticky overflow when D digits are too few.
module bin_bcd_seq #(
  parameter int W      = 16,
  parameter int D      = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  bin_bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * D;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_ovf_q, acc_ovf_d;
  logic            sgn_q, sgn_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [BW-1:0]   scr_adj;
  logic            bin_neg;
  logic [W-1:0]    bin_mag;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int k = 0; k < D; k++) begin
      if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign scr_adj = add3(scr_q);
  // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude
  assign bin_neg = SIGNED & bus.bin[W-1];
  assign bin_mag = bin_neg ? (W'(0) - bus.bin) : bus.bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      acc_ovf_q <= 1'b0;
      sgn_q     <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      scr_q     <= scr_d;
      cnt_q     <= cnt_d;
      acc_ovf_q <= acc_ovf_d;
      sgn_q     <= sgn_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    acc_ovf_d = acc_ovf_q;
    sgn_d     = sgn_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d      = bin_mag;
          sgn_d     = bin_neg;
          scr_d     = '0;
          cnt_d     = '0;
          acc_ovf_d = 1'b0;
          state_d   = CONV;
        end
      end
      CONV: begin
        scr_d     = {scr_adj[BW-2:0], sh_q[W-1]};
        sh_d      = sh_q << 1;
        acc_ovf_d = acc_ovf_q | scr_adj[BW-1];
        cnt_d     = cnt_q + 1'b1;
        // last shift: publish the result in the same edge as the final shift
        if (cnt_q == CW'(W - 1)) begin
          bcd_d   = scr_d;
          neg_d   = sgn_q;
          ovf_d   = acc_ovf_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.neg      = neg_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// Bench for bin_bcd_seq across four configurations, with a queue of expected
// results pushed on accept and popped on done.
module tb_bin_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin_bcd_seq_if #(.W(16), .D(5)) ifa ();
  bin_bcd_seq_if #(.W(16), .D(4)) ifb ();
  bin_bcd_seq_if #(.W(8),  .D(3)) ifc ();
  bin_bcd_seq_if #(.W(10), .D(4)) ife ();

  bin_bcd_seq #(.W(16), .D(5), .SIGNED(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bin_bcd_seq #(.W(16), .D(4), .SIGNED(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  bin_bcd_seq #(.W(8),  .D(3), .SIGNED(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  bin_bcd_seq #(.W(10), .D(4), .SIGNED(1'b0)) dut_e (.clk(clk), .rst_n(rst_n), .bus(ife));

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [19:0] dec(input int unsigned v, input int nd);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t mk(input int unsigned mag, input int nd, input logic ng);
    exp_t e;
    int unsigned lim;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    e.bcd = dec(mag, nd);
    e.neg = ng;
    e.ovf = (mag >= lim);
    return e;
  endfunction

  // done must never coincide with ready low
  always @(negedge clk) begin
    if (ifa.done) begin
      n_checks++;
      if (ifa.ready !== 1'b1) begin n_fail++; $display("FAIL done_ready_a: ready=%b required 1", ifa.ready); end
    end
    if (ife.done) begin
      n_checks++;
      if (ife.ready !== 1'b1) begin n_fail++; $display("FAIL done_ready_e: ready=%b required 1", ife.ready); end
    end
  end

  task automatic test_reset();
    exp_t e;
    bit seen;
    int lat;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks += 5;
    if (ifa.ready !== 1'b1)     begin n_fail++; $display("FAIL rst_ready: got %b need 1", ifa.ready); end
    if (ifa.done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b need 0", ifa.done); end
    if (ifa.bcd !== 20'h0)      begin n_fail++; $display("FAIL rst_bcd: got %h need 0", ifa.bcd); end
    if (ifa.neg !== 1'b0)       begin n_fail++; $display("FAIL rst_neg: got %b need 0", ifa.neg); end
    if (ifa.overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_ovf: got %b need 0", ifa.overflow); end
    // give the outputs a non-zero value so the mid-conversion reset is visible
    ifa.start = 1'b1; ifa.bin = 16'd777; sb.push_back(mk(777, 5, 1'b0));
    @(negedge clk);
    ifa.start = 1'b0;
    seen = 0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (ifa.done) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_pre_done: timeout, need done"); sb.delete(); end
    else begin
      e = sb.pop_front();
      n_checks++;
      if (ifa.bcd !== e.bcd) begin n_fail++; $display("FAIL rst_pre_bcd: got %h need %h", ifa.bcd, e.bcd); end
    end
    ifa.start = 1'b1; ifa.bin = 16'd12345;
    @(negedge clk);
    ifa.start = 1'b0; ifa.bin = 16'd0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (ifa.ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b need 1", ifa.ready); end
    if (ifa.bcd !== 20'h0)  begin n_fail++; $display("FAIL rst_mid_bcd: got %h need 0", ifa.bcd); end
    if (ifa.done !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_done: got %b need 0", ifa.done); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifa.done) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got done=%b need 0", seen); end
  endtask

  task automatic test_defaults();
    logic [15:0] vals[7];
    exp_t e;
    int lat;
    bit seen;
    vals = '{16'hFFFF, 16'd0, 16'd9, 16'd10, 16'd12345, 16'd99, 16'(($urandom % 65536))};
    foreach (vals[i]) begin
      n_checks++;
      if (ifa.ready !== 1'b1) begin n_fail++; $display("FAIL def_ready_idle[%0d]: got %b need 1", i, ifa.ready); end
      ifa.start = 1'b1; ifa.bin = vals[i]; sb.push_back(mk(vals[i], 5, 1'b0));
      @(negedge clk);
      ifa.start = 1'b0; ifa.bin = 16'($urandom);
      n_checks++;
      if (ifa.ready !== 1'b0) begin n_fail++; $display("FAIL def_ready_busy[%0d]: got %b need 0", i, ifa.ready); end
      seen = 0;
      for (lat = 1; lat <= 40; lat++) begin
        @(negedge clk);
        if (ifa.done) begin seen = 1; break; end
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL def_timeout[%0d]: no done, need done", i); sb.delete(); continue; end
      e = sb.pop_front();
      n_checks += 4;
      if (lat !== 16)              begin n_fail++; $display("FAIL def_lat[%0d]: got %0d need 16", i, lat); end
      if (ifa.bcd !== e.bcd)       begin n_fail++; $display("FAIL def_bcd[%0d]: got %h need %h", i, ifa.bcd, e.bcd); end
      if (ifa.overflow !== e.ovf)  begin n_fail++; $display("FAIL def_ovf[%0d]: got %b need %b", i, ifa.overflow, e.ovf); end
      if (ifa.neg !== 1'b0)        begin n_fail++; $display("FAIL def_neg[%0d]: got %b need 0", i, ifa.neg); end
      @(negedge clk);
      n_checks++;
      if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL def_done_pulse[%0d]: got %b need 0", i, ifa.done); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] vals[5];
    exp_t e;
    bit seen;
    vals = '{16'd65535, 16'd9999, 16'd10000, 16'd0, 16'd10001};
    foreach (vals[i]) begin
      ifb.start = 1'b1; ifb.bin = vals[i]; sb.push_back(mk(vals[i], 4, 1'b0));
      @(negedge clk);
      ifb.start = 1'b0;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (ifb.done) begin seen = 1; break; end
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL ovf_timeout[%0d]: no done, need done", i); sb.delete(); continue; end
      e = sb.pop_front();
      n_checks += 2;
      if ({4'h0, ifb.bcd} !== e.bcd) begin n_fail++; $display("FAIL ovf_bcd[%0d]: got %h need %h", i, ifb.bcd, e.bcd[15:0]); end
      if (ifb.overflow !== e.ovf)    begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b need %b", i, ifb.overflow, e.ovf); end
    end
  endtask

  task automatic test_signed();
    logic [7:0] vals[6];
    exp_t e;
    bit seen;
    int unsigned mag;
    vals = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'h9C};
    foreach (vals[i]) begin
      mag = vals[i][7] ? (256 - int'(vals[i])) : int'(vals[i]);
      ifc.start = 1'b1; ifc.bin = vals[i]; sb.push_back(mk(mag, 3, vals[i][7]));
      @(negedge clk);
      ifc.start = 1'b0;
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (ifc.done) begin seen = 1; break; end
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL sgn_timeout[%0d]: no done, need done", i); sb.delete(); continue; end
      e = sb.pop_front();
      n_checks += 3;
      if ({8'h0, ifc.bcd} !== e.bcd) begin n_fail++; $display("FAIL sgn_bcd[%0d]: got %h need %h", i, ifc.bcd, e.bcd[11:0]); end
      if (ifc.neg !== e.neg)         begin n_fail++; $display("FAIL sgn_neg[%0d]: got %b need %b", i, ifc.neg, e.neg); end
      if (ifc.overflow !== e.ovf)    begin n_fail++; $display("FAIL sgn_ovf[%0d]: got %b need %b", i, ifc.overflow, e.ovf); end
    end
  endtask

  task automatic test_handshake();
    exp_t e;
    bit seen;
    int lat, cyc, ndone;
    int t[3];
    ifa.start = 1'b1; ifa.bin = 16'd1111; sb.push_back(mk(1111, 5, 1'b0));
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (2) @(negedge clk);
    ifa.start = 1'b1; ifa.bin = 16'd2222;
    @(negedge clk);
    ifa.start = 1'b0; ifa.bin = 16'd0;
    seen = 0;
    for (lat = 4; lat <= 40; lat++) begin
      @(negedge clk);
      if (ifa.done) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL hs_timeout: no done, need done"); sb.delete(); end
    else begin
      e = sb.pop_front();
      n_checks += 2;
      if (ifa.bcd !== e.bcd) begin n_fail++; $display("FAIL hs_ignore_bcd: got %h need %h", ifa.bcd, e.bcd); end
      if (lat !== 16)        begin n_fail++; $display("FAIL hs_ignore_lat: got %0d need 16", lat); end
    end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (ifa.done) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL hs_not_queued: got done=%b need 0", seen); end
    // start held high: results must come every W+1 cycles
    ifa.start = 1'b1; ifa.bin = 16'd500;
    ndone = 0;
    for (cyc = 0; cyc < 100 && ndone < 3; cyc++) begin
      @(negedge clk);
      if (ifa.done) begin
        t[ndone] = cyc;
        ndone++;
        n_checks++;
        if (ifa.bcd !== 20'h00500) begin n_fail++; $display("FAIL hs_hold_bcd: got %h need 00500", ifa.bcd); end
        if (ndone == 3) ifa.start = 1'b0;
      end
    end
    ifa.start = 1'b0;
    n_checks++;
    if (ndone !== 3) begin n_fail++; $display("FAIL hs_hold_count: got %0d need 3", ndone); end
    else begin
      n_checks += 2;
      if (t[1] - t[0] !== 17) begin n_fail++; $display("FAIL hs_spacing1: got %0d need 17", t[1] - t[0]); end
      if (t[2] - t[1] !== 17) begin n_fail++; $display("FAIL hs_spacing2: got %0d need 17", t[2] - t[1]); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int next_v, ndone, nbad;
    next_v = 0; ndone = 0; nbad = 0;
    for (int cyc = 0; cyc < 1024 * 11 + 100 && ndone < 1024; cyc++) begin
      @(negedge clk);
      if (ife.done) begin
        ndone++;
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL sweep_extra_done: got done with empty queue, need none");
        end else begin
          e = sb.pop_front();
          n_checks += 2;
          if ({4'h0, ife.bcd} !== e.bcd) begin
            n_fail++; nbad++;
            if (nbad < 10) $display("FAIL sweep_bcd: got %h need %h", ife.bcd, e.bcd[15:0]);
          end
          if (ife.overflow !== 1'b0) begin
            n_fail++; nbad++;
            if (nbad < 10) $display("FAIL sweep_ovf: got %b need 0", ife.overflow);
          end
        end
      end
      if (ife.ready) begin
        if (next_v < 1024) begin
          ife.start = 1'b1; ife.bin = 10'(next_v);
          sb.push_back(mk(next_v, 4, 1'b0));
          next_v++;
        end else ife.start = 1'b0;
      end
    end
    ife.start = 1'b0;
    n_checks += 2;
    if (ndone !== 1024)    begin n_fail++; $display("FAIL sweep_count: got %0d need 1024", ndone); end
    if (sb.size() !== 0)   begin n_fail++; $display("FAIL sweep_queue: got %0d left need 0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    ifa.start = 1'b0; ifa.bin = '0;
    ifb.start = 1'b0; ifb.bin = '0;
    ifc.start = 1'b0; ifc.bin = '0;
    ife.start = 1'b0; ife.bin = '0;
    test_reset();
    test_defaults();
    test_overflow();
    test_signed();
    test_handshake();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
